// File: rtl/spi_master_rx_assembler.sv
// SPI master receive path: byte FIFO feeding an LSB-first word assembler that emits emesh writes.
// Optional partial-word flush on idle timeout is enabled by defining SPI_RX_TIMEOUT_EN.
module spi_master_rx_assembler #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 32,
  parameter int unsigned PW      = 104,
  parameter int unsigned SW      = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_spi_en,
  input  logic [1:0]    i_rx_datamode,
  input  logic [AW-1:0] i_rx_dstaddr,
  input  logic          i_ovf_clear,
  input  logic          i_rx_access,
  input  logic [SW-1:0] i_rx_data,
  output logic          o_rx_wait,
  output logic          o_access_out,
  output logic [PW-1:0] o_packet_out,
  input  logic          i_wait_in,
  output logic          o_fifo_empty,
  output logic          o_overflow
);

  localparam int unsigned FAW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StFill, StSend} state_e;

  logic [SW-1:0] r_mem [DEPTH];
  logic [FAW:0]  r_wr_ptr, r_rd_ptr;
  logic          r_overflow;
  state_e        r_state;
  logic [1:0]    r_mode;
  logic [3:0]    r_cnt;
  logic [63:0]   r_word;

  logic          w_empty, w_full, w_pop, w_push, w_drop;
  logic [SW-1:0] w_rd_byte;
  logic [4:0]    w_ctrl;
  logic [PW-1:0] w_packet;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[FAW] != r_rd_ptr[FAW]) &&
                     (r_wr_ptr[FAW-1:0] == r_rd_ptr[FAW-1:0]);
  // The assembler never pops while a packet is waiting to be taken.
  assign w_pop     = i_spi_en & ~w_empty & (r_state != StSend);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push    = i_rx_access & i_spi_en & (~w_full | w_pop);
  assign w_drop    = i_rx_access & i_spi_en & ~w_push;
  assign w_rd_byte = r_mem[r_rd_ptr[FAW-1:0]];

`ifdef SPI_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo;
  logic          r_partial;
  assign w_ctrl = {4'b0000, r_partial};
`else
  assign w_ctrl = 5'(TIMEOUT * 0);
`endif

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[FAW-1:0]] <= i_rx_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_state    <= StIdle;
      r_mode     <= 2'd0;
      r_cnt      <= 4'd0;
      r_word     <= '0;
`ifdef SPI_RX_TIMEOUT_EN
      r_tmo      <= '0;
      r_partial  <= 1'b0;
`endif
    end else begin
      if (!i_spi_en) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      if (w_drop)           r_overflow <= 1'b1;
      else if (i_ovf_clear) r_overflow <= 1'b0;

`ifdef SPI_RX_TIMEOUT_EN
      r_tmo <= '0;
`endif
      case (r_state)
        StIdle: begin
          // The first byte is consumed on the same edge the word is opened.
          if (w_pop) begin
            r_mode  <= i_rx_datamode;
            r_word  <= {{(64-SW){1'b0}}, w_rd_byte};
            r_cnt   <= 4'd1;
            r_state <= (i_rx_datamode == 2'd0) ? StSend : StFill;
`ifdef SPI_RX_TIMEOUT_EN
            r_partial <= 1'b0;
`endif
          end
        end
        StFill: begin
          if (!i_spi_en) begin
            r_state <= StIdle;
          end else if (w_pop) begin
            r_word[int'(r_cnt[2:0])*SW +: SW] <= w_rd_byte;
            r_cnt <= r_cnt + 4'd1;
            if ((r_cnt + 4'd1) == (4'd1 << r_mode)) r_state <= StSend;
          end
`ifdef SPI_RX_TIMEOUT_EN
          else if (r_cnt != 4'd0) begin
            if (r_tmo == TW'(TIMEOUT - 1)) begin
              r_state   <= StSend;
              r_partial <= 1'b1;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
`endif
        end
        StSend: begin
          if (!i_wait_in) begin
            if (i_spi_en && !w_empty) begin
              r_state <= StFill;
              r_mode  <= i_rx_datamode;
              r_cnt   <= 4'd0;
              r_word  <= '0;
`ifdef SPI_RX_TIMEOUT_EN
              r_partial <= 1'b0;
`endif
            end else begin
              r_state <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    w_packet                   = '0;
    w_packet[0]                = 1'b1;
    w_packet[2:1]              = r_mode;
    w_packet[7:3]              = w_ctrl;
    w_packet[AW+7:8]           = i_rx_dstaddr;
    w_packet[2*AW+7:AW+8]      = r_word[31:0];
    w_packet[2*AW+39:2*AW+8]   = r_word[63:32];
  end

  assign o_access_out = (r_state == StSend);
  assign o_packet_out = o_access_out ? w_packet : '0;
  assign o_rx_wait    = w_full;
  assign o_fifo_empty = w_empty;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_spi_master_rx_assembler.sv
// Self-checking bench for spi_master_rx_assembler; define SPI_RX_TIMEOUT_EN to expect timeout flushes.
module tb_spi_master_rx_assembler;
  localparam int unsigned DEPTH = 16, AW = 32, PW = 104, SW = 8, TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          reset, spi_en, ovf_clear, rx_access, wait_in;
  logic [1:0]    rx_datamode;
  logic [AW-1:0] rx_dstaddr;
  logic [SW-1:0] rx_data;
  logic          rx_wait, access_out, fifo_empty, overflow;
  logic [PW-1:0] packet_out;

  spi_master_rx_assembler #(.DEPTH(DEPTH), .AW(AW), .PW(PW), .SW(SW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(reset), .i_spi_en(spi_en), .i_rx_datamode(rx_datamode),
    .i_rx_dstaddr(rx_dstaddr), .i_ovf_clear(ovf_clear), .i_rx_access(rx_access),
    .i_rx_data(rx_data), .o_rx_wait(rx_wait), .o_access_out(access_out),
    .o_packet_out(packet_out), .i_wait_in(wait_in), .o_fifo_empty(fifo_empty),
    .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [PW-1:0] got_q[$], exp_q[$];
  logic [7:0]    bytes_q[$];

  // Every packet taken by the core (valid with no pushback) is logged.
  always @(negedge clk) if (!reset && access_out && !wait_in) got_q.push_back(packet_out);

  function automatic logic [PW-1:0] mk_pkt(input logic [1:0] mode, input logic [63:0] word,
                                           input logic partial);
    logic [PW-1:0] p;
    p = '0;
    p[0] = 1'b1;
    p[2:1] = mode;
    p[3] = partial;
    p[AW+7:8] = rx_dstaddr;
    p[2*AW+7:AW+8] = word[31:0];
    p[2*AW+39:2*AW+8] = word[63:32];
    return p;
  endfunction

  // Expected packets: complete groups of 2**mode bytes, first byte in the low lane.
  task automatic build_exp(input logic [1:0] mode);
    int per;
    logic [63:0] w;
    per = 1 << mode;
    exp_q.delete();
    for (int s = 0; s + per <= bytes_q.size(); s += per) begin
      w = '0;
      for (int k = 0; k < per; k++) w = w | (64'(bytes_q[s+k]) << (8 * k));
      exp_q.push_back(mk_pkt(mode, w, 1'b0));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_access = 1'b1;
    rx_data = b;
    tick(1);
    rx_access = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      tick(1);
      c++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; spi_en = 1'b1; ovf_clear = 1'b0; rx_access = 1'b0; wait_in = 1'b0;
    tick(2);
    reset = 1'b0;
    got_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    n_tests += 5;
    if (access_out !== 1'b0) begin n_fail++; $display("FAIL reset_access got=%b exp=0", access_out); end
    if (rx_wait !== 1'b0) begin n_fail++; $display("FAIL reset_rx_wait got=%b exp=0", rx_wait); end
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", fifo_empty); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    if (packet_out !== '0) begin n_fail++; $display("FAIL reset_packet got=%h exp=0", packet_out); end
    reset = 1'b0;
    got_q.delete();
  endtask

  task automatic test_mode2();
    logic [PW-1:0] e;
    got_q.delete();
    rx_datamode = 2'd2;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_got(1, 20);
    tick(5);
    e = mk_pkt(2'd2, 64'h0000_0000_4433_2211, 1'b0);
    n_tests += 3;
    if (got_q.size() != 1) begin n_fail++; $display("FAIL mode2_count got=%0d exp=1", got_q.size()); end
    if (got_q[0] !== e) begin n_fail++; $display("FAIL mode2_pkt got=%h exp=%h", got_q[0], e); end
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL mode2_empty got=%b exp=1", fifo_empty); end
  endtask

  task automatic test_mode3();
    logic [PW-1:0] e;
    got_q.delete();
    rx_datamode = 2'd3;
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    wait_got(1, 30);
    tick(5);
    e = mk_pkt(2'd3, 64'h0807_0605_0403_0201, 1'b0);
    n_tests += 2;
    if (got_q.size() != 1) begin n_fail++; $display("FAIL mode3_count got=%0d exp=1", got_q.size()); end
    if (got_q[0] !== e) begin n_fail++; $display("FAIL mode3_pkt got=%h exp=%h", got_q[0], e); end
  endtask

  task automatic test_overflow();
    got_q.delete();
    bytes_q.delete();
    rx_datamode = 2'd0;
    wait_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      // One byte sits in the stalled packet, DEPTH more fill the FIFO; the rest are lost.
      if (i <= DEPTH + 1) bytes_q.push_back(8'(i));
      send_byte(8'(i));
    end
    n_tests += 3;
    if (rx_wait !== 1'b1) begin n_fail++; $display("FAIL ovf_rx_wait got=%b exp=1", rx_wait); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    if (got_q.size() != 0) begin n_fail++; $display("FAIL ovf_stall_count got=%0d exp=0", got_q.size()); end
    rx_access = 1'b1; rx_data = 8'hEE; ovf_clear = 1'b1;
    tick(1);
    rx_access = 1'b0;
    n_tests++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
    tick(1);
    ovf_clear = 1'b0;
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    wait_in = 1'b0;
    build_exp(2'd0);
    wait_got(exp_q.size(), 200);
    tick(5);
    n_tests += 2;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL ovf_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained got=%b exp=1", fifo_empty); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL ovf_pkt%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wait_stall();
    logic [PW-1:0] snap;
    int c = 0;
    got_q.delete();
    bytes_q.delete();
    rx_datamode = 2'd2;
    wait_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bytes_q.push_back(8'($urandom));
      send_byte(bytes_q[i]);
    end
    while (!access_out && c < 20) begin tick(1); c++; end
    snap = packet_out;
    build_exp(2'd2);
    n_tests++;
    if (snap !== exp_q[0]) begin n_fail++; $display("FAIL stall_first got=%h exp=%h", snap, exp_q[0]); end
    for (int i = 0; i < 10; i++) begin
      tick(1);
      n_tests++;
      if (access_out !== 1'b1 || packet_out !== snap) begin
        n_fail++; $display("FAIL stall_hold%0d got=%b/%h exp=1/%h", i, access_out, packet_out, snap);
      end
    end
    wait_in = 1'b0;
    wait_got(2, 40);
    tick(3);
    n_tests++;
    if (got_q.size() != 2) begin n_fail++; $display("FAIL stall_count got=%0d exp=2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL stall_pkt%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_spi_en();
    logic [PW-1:0] e;
    got_q.delete();
    rx_datamode = 2'd2;
    send_byte(8'hA1); send_byte(8'hA2);
    spi_en = 1'b0;
    tick(1);
    n_tests++;
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL en_flush got=%b exp=1", fifo_empty); end
    send_byte(8'hA3);
    tick(4);
    n_tests += 3;
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL en_blocked got=%b exp=1", fifo_empty); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL en_ovf got=%b exp=0", overflow); end
    if (got_q.size() != 0 || access_out !== 1'b0) begin
      n_fail++; $display("FAIL en_no_pkt got=%0d/%b exp=0/0", got_q.size(), access_out);
    end
    spi_en = 1'b1;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_got(1, 20);
    tick(5);
    e = mk_pkt(2'd2, 64'h0000_0000_0403_0201, 1'b0);
    n_tests += 2;
    if (got_q.size() != 1) begin n_fail++; $display("FAIL en_count got=%0d exp=1", got_q.size()); end
    if (got_q[0] !== e) begin n_fail++; $display("FAIL en_pkt got=%h exp=%h", got_q[0], e); end
  endtask

  task automatic test_random();
    logic [1:0] mode;
    int words;
    for (int it = 0; it < 8; it++) begin
      got_q.delete();
      bytes_q.delete();
      mode = 2'($urandom_range(0, 3));
      words = $urandom_range(1, 2);
      rx_datamode = mode;
      for (int i = 0; i < (words << mode); i++) bytes_q.push_back(8'($urandom));
      foreach (bytes_q[i]) begin
        repeat ($urandom_range(0, 2)) begin wait_in = 1'($urandom); tick(1); end
        wait_in = 1'($urandom);
        send_byte(bytes_q[i]);
      end
      repeat (20) begin wait_in = 1'($urandom); tick(1); end
      wait_in = 1'b0;
      build_exp(mode);
      wait_got(exp_q.size(), 60);
      tick(3);
      n_tests += 2;
      if (got_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rnd%0d_count got=%0d exp=%0d", it, got_q.size(), exp_q.size());
      end
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_ovf got=%b exp=0", it, overflow); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rnd%0d_pkt%0d got=%h exp=%h", it, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    got_q.delete();
    rx_datamode = 2'd0;
    wait_in = 1'b1;
    send_byte(8'h5A);
    tick(1);
    n_tests++;
    if (access_out !== 1'b1) begin n_fail++; $display("FAIL rmid_pending got=%b exp=1", access_out); end
    reset = 1'b1;
    tick(1);
    n_tests += 2;
    if (access_out !== 1'b0) begin n_fail++; $display("FAIL rmid_access got=%b exp=0", access_out); end
    if (packet_out !== '0) begin n_fail++; $display("FAIL rmid_packet got=%h exp=0", packet_out); end
    reset = 1'b0;
    wait_in = 1'b0;
    tick(5);
    n_tests++;
    if (got_q.size() != 0) begin n_fail++; $display("FAIL rmid_count got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_timeout();
    logic [PW-1:0] e;
    got_q.delete();
    rx_datamode = 2'd2;
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    tick(TIMEOUT + 10);
    e = mk_pkt(2'd2, 64'h0000_0000_00CC_BBAA, 1'b1);
`ifdef SPI_RX_TIMEOUT_EN
    n_tests += 2;
    if (got_q.size() != 1) begin n_fail++; $display("FAIL tmo_count got=%0d exp=1", got_q.size()); end
    if (got_q[0] !== e) begin n_fail++; $display("FAIL tmo_pkt got=%h exp=%h", got_q[0], e); end
`else
    n_tests += 2;
    if (got_q.size() != 0) begin n_fail++; $display("FAIL tmo_none got=%0d exp=0 (%h)", got_q.size(), e); end
    if (access_out !== 1'b0) begin n_fail++; $display("FAIL tmo_access got=%b exp=0", access_out); end
`endif
    do_reset();
  endtask

  initial begin
    reset = 1'b1; spi_en = 1'b1; ovf_clear = 1'b0; rx_access = 1'b0; wait_in = 1'b0;
    rx_datamode = 2'd0; rx_data = '0; rx_dstaddr = 32'hC0DE_1234;
    test_reset();
    test_mode2();
    test_mode3();
    test_overflow();
    test_wait_stall();
    test_spi_en();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
